// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, derived totals, counter width and
// colour-bar constants shared by the VGA output path.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  localparam int H_TOTAL_D      = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int V_TOTAL_D      = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;
  localparam int H_SYNC_START_D = H_ACTIVE_D + H_FP_D;
  localparam int H_SYNC_END_D   = H_SYNC_START_D + H_SYNC_D;
  localparam int V_SYNC_START_D = V_ACTIVE_D + V_FP_D;
  localparam int V_SYNC_END_D   = V_SYNC_START_D + V_SYNC_D;

  // Colour bars are 80 pixels wide, eight across the active line
  localparam int BAR_W = 80;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  // Timing flags travelling down the pixel-latency delay line
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic frame_start;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0, frame_start: 1'b0};

  function automatic logic [2:0] bar_idx(input logic [CNT_W-1:0] x);
    return 3'(x / CNT_W'(BAR_W));
  endfunction

  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: fixed-depth shift register that lines timing flags up with
// the image source latency; stages reset asynchronously to IDLE.
module vga_sync_delay #(
  parameter int               DEPTH = 1,
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] IDLE  = '0
) (
  input  logic             vga_clk,
  input  logic             arst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift one stage per pixel clock
  always_ff @(posedge vga_clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= IDLE;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_out.sv
// vga_out: 640x480 VGA timing master and pixel sink. Issues coordinates to an
// image source, takes its RGB PIX_LAT clocks later and drives registered,
// blank-masked RGB with aligned sync, de and frame_start.
// Optional build macro VGA_OUT_PATTERN_EN adds pattern_sel for colour bars.
module vga_out
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter int PIX_LAT  = 1
) (
  input  logic             vga_clk,
  input  logic             arst_n,
`ifdef VGA_OUT_PATTERN_EN
  input  logic             pattern_sel,
`endif
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             pix_req,
  input  logic [7:0]       red,
  input  logic [7:0]       green,
  input  logic [7:0]       blue,
  output logic [7:0]       vga_r,
  output logic [7:0]       vga_g,
  output logic [7:0]       vga_b,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic             vga_de,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  sync_t            raw_sync;
  sync_t            dly_sync;
  logic [23:0]      pix_rgb;

  // Free-running raster counters; v advances on every h wrap
  always_ff @(posedge vga_clk or negedge arst_n) begin
    if (!arst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign pix_x   = h_cnt;
  assign pix_y   = v_cnt;
  assign pix_req = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);

  assign raw_sync.hsync       = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign raw_sync.vsync       = !((v_cnt >= VS_START) && (v_cnt < VS_END));
  assign raw_sync.de          = pix_req;
  assign raw_sync.frame_start = (h_cnt == '0) && (v_cnt == '0);

  vga_sync_delay #(
    .DEPTH (PIX_LAT),
    .WIDTH (4),
    .IDLE  (SYNC_IDLE)
  ) u_sync_delay (
    .vga_clk (vga_clk),
    .arst_n  (arst_n),
    .d       (raw_sync),
    .q       (dly_sync)
  );

`ifdef VGA_OUT_PATTERN_EN
  logic [2:0] raw_bar;
  logic [2:0] dly_bar;

  assign raw_bar = bar_idx(h_cnt);

  // Bar index follows the same latency as the timing flags
  vga_sync_delay #(
    .DEPTH (PIX_LAT),
    .WIDTH (3),
    .IDLE  (3'd0)
  ) u_bar_delay (
    .vga_clk (vga_clk),
    .arst_n  (arst_n),
    .d       (raw_bar),
    .q       (dly_bar)
  );

  assign pix_rgb = pattern_sel ? bar_rgb(dly_bar) : {red, green, blue};
`else
  assign pix_rgb = {red, green, blue};
`endif

  // Output register: RGB forced to zero outside active video so blanking
  // values from the source (including X) never reach the DAC
  always_ff @(posedge vga_clk or negedge arst_n) begin
    if (!arst_n) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_de      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vga_hsync   <= dly_sync.hsync;
      vga_vsync   <= dly_sync.vsync;
      vga_de      <= dly_sync.de;
      frame_start <= dly_sync.frame_start;
      if (dly_sync.de) {vga_r, vga_g, vga_b} <= pix_rgb;
      else             {vga_r, vga_g, vga_b} <= '0;
    end
  end

endmodule

// File: doc/vga_out.md
# vga_out

Pixel sink and VGA timing master for the 640x480@60 Hz video path. Runs free on `vga_clk`, generates horizontal/vertical counters and sync, and issues pixel coordinates to an image-generator block. It accepts that block's 8-bit RGB after a fixed latency and drives the registered, blank-masked RGB plus aligned hsync, vsync and data-enable to the DAC/connector.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync pulse width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch
- `PIX_LAT`, 1, image-source latency in clocks, legal range 1..4

Ports:
- `vga_clk`  in  1  pixel clock (25.175 MHz nominal)
- `arst_n`  in  1  reset, asynchronous assert, active-low
- `pix_x`  out  10  current horizontal count (0..H_TOTAL-1)
- `pix_y`  out  10  current vertical count (0..V_TOTAL-1)
- `pix_req`  out  1  high when (pix_x, pix_y) is in the active area
- `red`, `green`, `blue`  in  8 each  pixel from the image source, valid PIX_LAT clocks after its coordinates
- `vga_r`, `vga_g`, `vga_b`  out  8 each  registered RGB to the DAC
- `vga_hsync`, `vga_vsync`  out  1  sync, active-low
- `vga_de`  out  1  active-video enable
- `frame_start`  out  1  one-clock pulse aligned with the first output pixel of a frame

## Operation
- H_TOTAL = 800 and V_TOTAL = 525 with default parameters. Counters `h_cnt` and `v_cnt` are registered and drive `pix_x` and `pix_y` directly.
- `h_cnt` increments each clock. When `h_cnt == H_TOTAL-1`, `h_cnt` wraps to 0 and `v_cnt` increments. When `v_cnt == V_TOTAL-1` and `h_cnt` wraps, `v_cnt` wraps to 0.
- `pix_req` = (`h_cnt` < H_ACTIVE) and (`v_cnt` < V_ACTIVE). It is combinational from the counters.
- Raw hsync is low while `h_cnt` is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [656,752) with defaults. Raw vsync is low while `v_cnt` is in [490,492), for entire lines.
- Raw de = `pix_req`. Raw frame_start = (`h_cnt` == 0 and `v_cnt` == 0).
- Raw hsync, vsync, de and frame_start pass through a PIX_LAT-deep delay line. The delayed values are then registered together with RGB.
- Output RGB = input RGB when delayed de = 1, otherwise 0. Input values during blanking, including X, never reach the outputs.
- The source must hold or ignore no state: the block applies no backpressure, and the counters never stall.

## Timing
- Counter value present in cycle n → RGB sampled at the clock edge ending cycle n+PIX_LAT → all `vga_*` outputs and `frame_start` for that pixel are visible in cycle n+PIX_LAT+1.
- Line period: 800 clocks. Frame period: 420000 clocks. `frame_start` period: 420000 clocks.
- Reset values, forced immediately on `arst_n` low:
  - `h_cnt` = `v_cnt` = 0
  - `vga_r/g/b` = 0, `vga_de` = 0, `frame_start` = 0
  - `vga_hsync` = `vga_vsync` = 1
  - all delay-line stages = idle (sync 1, de 0, frame_start 0)
- After `arst_n` deasserts, `pix_x` = 0 and `pix_y` = 0 hold in the first clock. The first `frame_start` appears PIX_LAT+1 clocks later.
- Reset mid-line or mid-frame aborts the frame with no partial recovery. Timing restarts from (0,0).

## Configuration
- `VGA_OUT_PATTERN_EN` defined:
  - adds input `pattern_sel` (1 bit)
  - when `pattern_sel` = 1, output RGB during de is replaced by 8 vertical colour bars, each 80 pixels wide, from the delayed x
  - bar order: white, yellow, cyan, green, magenta, red, blue, black (components 8'hFF or 8'h00)
  - blanking masking still applies
- `VGA_OUT_PATTERN_EN` undefined: the port is absent and the input RGB is always used.

## Structure
- Package `vga_pkg`:
  - default timing constants
  - derived H_TOTAL, V_TOTAL, sync start/end values
  - counter width constant (10)
  - bar-colour constants
- Sub-module `vga_sync_delay`: parameterised-depth shift register, 4 bits wide (hsync, vsync, de, frame_start), with asynchronous reset to idle values.

## Test plan
- Assert reset mid-frame for 3 clocks → outputs at reset values immediately; after release, `frame_start` first seen at clock PIX_LAT+1 (2 with defaults).
- Free run for 2 frames → `vga_hsync` low for exactly 96 clocks every 800; `vga_vsync` low for exactly 1600 clocks every 420000; `vga_de` high for 640 clocks on each of 480 lines.
- Source returns RGB = {pix_x[7:0], pix_y[7:0], 8'h5A} with PIX_LAT = 1 and with PIX_LAT = 3 → output pixel at de position (x,y) equals that value for every active pixel.
- Source drives 8'hFF/X on all channels constantly → `vga_r/g/b` = 0 whenever `vga_de` = 0, and never X.
- Counter wrap → `pix_x` goes 799 → 0; `pix_y` goes 524 → 0 on the same clock as x wraps.
- With `VGA_OUT_PATTERN_EN` defined and `pattern_sel` = 1 → output at x = 0..79 is FF/FF/FF, x = 80 is FF/FF/00, x = 639 is 00/00/00.
